// File: rtl/riscv_pkg.sv
// Shared encodings for the core front end: FSM states, halt causes and the
// default halt instruction word.
package riscv_pkg;

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [1:0] HC_NONE      = 2'b00;
  localparam logic [1:0] HC_INV_ADDR  = 2'b01;
  localparam logic [1:0] HC_HALT_INSN = 2'b10;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_next_pc_mux.sv
// Next-PC selection (jump over branch over sequential) and the pc+4 link adder.
module next_pc_mux #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pc,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Wraps modulo 2^XLEN by construction.
  assign pc_plus4 = pc + PC_STEP;

  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = jump_target;
    else if (branch_taken)
      next_pc = branch_target;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner for the fetch stage: BOOT/RUN/HALTED sequencing,
// halt cause capture and a saturating retired-instruction counter.
//
//   state     | meaning
//   ST_BOOT   | one cycle after reset, pc held at RESET_PC, fetch not valid
//   ST_RUN    | fetching; pc advances unless stalled or halting
//   ST_HALTED | stopped on fault or halt instruction; only reset leaves
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter int               XLEN       = 64,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter logic [31:0]      HALT_INSTR = HALT_INSTR_DEFAULT,
  parameter int               CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             inv_addr,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             jump,
  input  logic [XLEN-1:0]  jump_target,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             fetch_valid,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]      state;
  logic [XLEN-1:0] next_pc;

  next_pc_mux #(.XLEN(XLEN)) u_next_pc_mux (
    .pc            (pc),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (next_pc),
    .pc_plus4      (pc_plus4)
  );

  assign fetch_valid = (state == ST_RUN);
  assign halted      = (state == ST_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_BOOT;
      pc            <= RESET_PC;
      halt_cause    <= HC_NONE;
      retired_count <= '0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (!stall) begin
            // Halting leaves pc on the offending address for debug.
            if (inv_addr) begin
              state      <= ST_HALTED;
              halt_cause <= HC_INV_ADDR;
            end else if (instruction == HALT_INSTR) begin
              state      <= ST_HALTED;
              halt_cause <= HC_HALT_INSN;
            end else begin
              pc <= next_pc;
              if (retired_count != '1)
                retired_count <= retired_count + CNT_ONE;
            end
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; a second narrow-counter
// instance exercises retired_count saturation.
module tb_pc_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic        inv_addr;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        jump;
  logic [63:0] jump_target;

  logic [63:0] pc, pc_plus4;
  logic        fetch_valid, halted;
  logic [1:0]  halt_cause;
  logic [31:0] retired_count;

  logic [63:0] pc_s, pc_plus4_s;
  logic        fetch_valid_s, halted_s;
  logic [1:0]  halt_cause_s;
  logic [2:0]  retired_count_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .inv_addr(inv_addr),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .halted(halted), .halt_cause(halt_cause),
    .retired_count(retired_count)
  );

  pc_sequencer #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .inv_addr(inv_addr),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .pc(pc_s), .pc_plus4(pc_plus4_s),
    .fetch_valid(fetch_valid_s), .halted(halted_s), .halt_cause(halt_cause_s),
    .retired_count(retired_count_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instruction   = NOP;
    inv_addr      = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 64'h0;
    jump          = 1'b0;
    jump_target   = 64'h0;
  endtask

  // Leaves the DUT in RUN with pc = 0.
  task automatic do_reset();
    idle_inputs();
    tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if (pc !== 64'h0 || fetch_valid !== 1'b0 || halted !== 1'b0 ||
        halt_cause !== 2'b00 || retired_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_state pc=%0h fv=%0b h=%0b hc=%0b cnt=%0d want 0/0/0/0/0",
               pc, fetch_valid, halted, halt_cause, retired_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || pc !== 64'h0) begin
      errors++;
      $display("FAIL boot_to_run fv=%0b pc=%0h want 1/0", fetch_valid, pc);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (pc !== 64'(4 * i) || retired_count !== 32'(i)) begin
        errors++;
        $display("FAIL seq_step%0d pc=%0h cnt=%0d want %0h/%0d", i, pc, retired_count, 4 * i, i);
      end
    end
  endtask

  task automatic test_branch_jump();
    do_reset();
    tick();
    tick();
    branch_taken  = 1'b1;
    branch_target = 64'h40;
    tick();
    checks++;
    if (pc !== 64'h40 || retired_count !== 32'd3) begin
      errors++;
      $display("FAIL branch pc=%0h cnt=%0d want 40/3", pc, retired_count);
    end
    jump        = 1'b1;
    jump_target = 64'h80;
    tick();
    checks++;
    if (pc !== 64'h80 || retired_count !== 32'd4) begin
      errors++;
      $display("FAIL jump_over_branch pc=%0h cnt=%0d want 80/4", pc, retired_count);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    stall       = 1'b1;
    jump        = 1'b1;
    jump_target = 64'h200;
    inv_addr    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 64'h10 || retired_count !== 32'd4 || halted !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d pc=%0h cnt=%0d h=%0b want 10/4/0", i, pc, retired_count, halted);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (pc !== 64'h14 || retired_count !== 32'd5) begin
      errors++;
      $display("FAIL stall_release pc=%0h cnt=%0d want 14/5", pc, retired_count);
    end
  endtask

  task automatic test_inv_addr();
    do_reset();
    jump        = 1'b1;
    jump_target = 64'h102;
    tick();
    checks++;
    if (pc !== 64'h102 || retired_count !== 32'd1) begin
      errors++;
      $display("FAIL misaligned_load pc=%0h cnt=%0d want 102/1", pc, retired_count);
    end
    jump     = 1'b0;
    inv_addr = 1'b1;
    tick();
    checks++;
    if (halted !== 1'b1 || halt_cause !== 2'b01 || pc !== 64'h102 ||
        retired_count !== 32'd1 || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL inv_addr_halt h=%0b hc=%0b pc=%0h cnt=%0d fv=%0b want 1/01/102/1/0",
               halted, halt_cause, pc, retired_count, fetch_valid);
    end
    inv_addr    = 1'b0;
    jump        = 1'b1;
    jump_target = 64'h300;
    tick();
    checks++;
    if (pc !== 64'h102 || halted !== 1'b1 || halt_cause !== 2'b01) begin
      errors++;
      $display("FAIL halted_frozen pc=%0h h=%0b hc=%0b want 102/1/01", pc, halted, halt_cause);
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    do_reset();
    inv_addr    = 1'b1;
    instruction = 32'h0;
    tick();
    checks++;
    if (halt_cause !== 2'b01 || pc !== 64'h0) begin
      errors++;
      $display("FAIL inv_over_halt hc=%0b pc=%0h want 01/0", halt_cause, pc);
    end
    do_reset();
    instruction = 32'h0;
    jump        = 1'b1;
    jump_target = 64'h80;
    tick();
    checks++;
    if (halt_cause !== 2'b10 || pc !== 64'h0 || retired_count !== 32'd0) begin
      errors++;
      $display("FAIL halt_over_jump hc=%0b pc=%0h cnt=%0d want 10/0/0", halt_cause, pc, retired_count);
    end
    idle_inputs();
  endtask

  task automatic test_halt_instr();
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    instruction = 32'h0;
    tick();
    checks++;
    if (halted !== 1'b1 || halt_cause !== 2'b10 || pc !== 64'h20 || retired_count !== 32'd8) begin
      errors++;
      $display("FAIL halt_instr h=%0b hc=%0b pc=%0h cnt=%0d want 1/10/20/8",
               halted, halt_cause, pc, retired_count);
    end
    instruction = NOP;
    jump        = 1'b1;
    jump_target = 64'h500;
    tick();
    tick();
    checks++;
    if (pc !== 64'h20 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halted_ignores_jump pc=%0h h=%0b want 20/1", pc, halted);
    end
    idle_inputs();
    rst_n = 1'b0;
    #2;
    checks++;
    if (pc !== 64'h0 || halted !== 1'b0 || fetch_valid !== 1'b0 ||
        halt_cause !== 2'b00 || retired_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_from_halted pc=%0h h=%0b fv=%0b hc=%0b cnt=%0d want 0/0/0/00/0",
               pc, halted, fetch_valid, halt_cause, retired_count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL rerun_after_reset fv=%0b want 1", fetch_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    jump        = 1'b1;
    jump_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    checks++;
    if (pc !== 64'hFFFF_FFFF_FFFF_FFFC || pc_plus4 !== 64'h0) begin
      errors++;
      $display("FAIL wrap_pc_plus4 pc=%0h pc4=%0h want fffffffffffffffc/0", pc, pc_plus4);
    end
    jump = 1'b0;
    tick();
    checks++;
    if (pc !== 64'h0 || halted !== 1'b0 || retired_count !== 32'd2) begin
      errors++;
      $display("FAIL wrap_step pc=%0h h=%0b cnt=%0d want 0/0/2", pc, halted, retired_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (retired_count_s !== 3'd7) begin
      errors++;
      $display("FAIL sat_reach cnt=%0d want 7", retired_count_s);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (retired_count_s !== 3'd7 || pc_s !== 64'h28 || retired_count !== 32'd10) begin
      errors++;
      $display("FAIL sat_stick cnt=%0d pc=%0h wide=%0d want 7/28/10",
               retired_count_s, pc_s, retired_count);
    end
  endtask

  initial begin
    test_reset();
    test_branch_jump();
    test_stall();
    test_inv_addr();
    test_priority();
    test_halt_instr();
    test_wrap();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
